// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared constants, FSM states and saturation helper for the voice mixer
package apu_pkg;

    localparam int NUM_VOICES = 4;
    localparam int SAMPLE_W   = 16;
    localparam int ACC_W      = 19;
    localparam int SAMP_MAX   = 32767;
    localparam int SAMP_MIN   = -32768;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAMP_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAMP_MIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > ACC_MAX) begin
            return SAMPLE_W'(SAMP_MAX);
        end else if (a < ACC_MIN) begin
            return SAMPLE_W'(SAMP_MIN);
        end else begin
            return a[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/voice_mixer_sched_voice_phase.sv
// rtl/voice_mixer_sched_voice_phase.sv - per-voice square-wave phase counter (cnt/pol)
module voice_phase #(
    parameter int HP_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            step_i,
    input  logic [HP_W-1:0] hp_i,
    output logic            pol_o
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            pol_q, pol_d;
    logic [HP_W:0]   cnt_inc;

    // One bit wider so cnt+1 never wraps before the compare against hp.
    assign cnt_inc = {1'b0, cnt_q} + (HP_W+1)'(1);
    assign pol_o   = pol_q;

    always_comb begin
        cnt_d = cnt_q;
        pol_d = pol_q;
        if (step_i) begin
            if (hp_i == '0) begin
                cnt_d = '0;
                pol_d = 1'b0;
            end else if (cnt_inc >= {1'b0, hp_i}) begin
                cnt_d = '0;
                pol_d = ~pol_q;
            end else begin
                cnt_d = cnt_inc[HP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            pol_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pol_q <= pol_d;
        end
    end

endmodule

// File: rtl/voice_mixer_sched.sv
// rtl/voice_mixer_sched.sv - four-voice time-multiplexed mixer; VOICE_MASK_EN adds voice_mask
module voice_mixer_sched
    import apu_pkg::*;
#(
    parameter logic [15:0] AMP      = 16'd4096,
    parameter int          SAMPLE_W = 16,
    parameter int          HP_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_req,
    input  logic [HP_W-1:0]     half_period0,
    input  logic [HP_W-1:0]     half_period1,
    input  logic [HP_W-1:0]     half_period2,
    input  logic [HP_W-1:0]     half_period3,
`ifdef VOICE_MASK_EN
    input  logic [3:0]          voice_mask,
`endif
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic [7:0]          overrun_cnt
);

    localparam logic signed [ACC_W-1:0] AMP_S = {3'b000, AMP};

    state_e                     state_q, state_d;
    logic [1:0]                 idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [SAMPLE_W-1:0]        out_q, out_d;
    logic                       valid_q, valid_d;
    logic [7:0]                 ovr_q, ovr_d;

    logic [HP_W-1:0]            hp [NUM_VOICES];
    logic [NUM_VOICES-1:0]      pol;
    logic [NUM_VOICES-1:0]      step;
    logic                       req;
    logic                       mute;
    logic [HP_W-1:0]            cur_hp;
    logic signed [ACC_W-1:0]    contrib;

    assign hp[0] = half_period0;
    assign hp[1] = half_period1;
    assign hp[2] = half_period2;
    assign hp[3] = half_period3;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign step[v] = (state_q == ST_ACCUM) && (idx_q == 2'(v));
        voice_phase #(.HP_W(HP_W)) u_phase (
            .clk    (clk),
            .reset  (reset),
            .step_i (step[v]),
            .hp_i   (hp[v]),
            .pol_o  (pol[v])
        );
    end

`ifdef VOICE_MASK_EN
    assign mute = voice_mask[idx_q];
`else
    assign mute = 1'b0;
`endif

    // Contribution uses the polarity before this service's update.
    assign cur_hp  = hp[idx_q];
    assign contrib = (cur_hp == '0 || mute) ? '0 : (pol[idx_q] ? AMP_S : -AMP_S);
    assign req     = enable && sample_req;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (req && state_q != ST_IDLE && ovr_q != 8'hff) begin
            ovr_d = ovr_q + 8'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    acc_d   = '0;
                    idx_d   = 2'd0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + contrib;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                // First OUT cycle latches the saturated sum; later cycles wait for the handshake.
                if (!valid_q) begin
                    out_d   = saturate(acc_q);
                    valid_d = 1'b1;
                end else if (sample_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_voice_mixer_sched.sv
// tb/tb_voice_mixer_sched.sv - self-checking bench for voice_mixer_sched at two amplitudes
module tb_voice_mixer_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_req;
    logic [15:0] hp [4];
    logic [3:0]  mask;
    logic        sample_ready;

    logic [15:0] out4, out16;
    logic        valid4, valid16, busy4, busy16;
    logic [7:0]  ovr4, ovr16;

    int total = 0;
    int bad   = 0;

    int m_cnt [4];
    int m_pol [4];
    int m_ovr;

    always #5 clk = ~clk;

    voice_mixer_sched #(.AMP(16'd4096), .SAMPLE_W(16), .HP_W(16)) u4 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_req   (sample_req),
        .half_period0 (hp[0]),
        .half_period1 (hp[1]),
        .half_period2 (hp[2]),
        .half_period3 (hp[3]),
`ifdef VOICE_MASK_EN
        .voice_mask   (mask),
`endif
        .sample_out   (out4),
        .sample_valid (valid4),
        .sample_ready (sample_ready),
        .busy         (busy4),
        .overrun_cnt  (ovr4)
    );

    voice_mixer_sched #(.AMP(16'd16384), .SAMPLE_W(16), .HP_W(16)) u16 (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_req   (sample_req),
        .half_period0 (hp[0]),
        .half_period1 (hp[1]),
        .half_period2 (hp[2]),
        .half_period3 (hp[3]),
`ifdef VOICE_MASK_EN
        .voice_mask   (mask),
`endif
        .sample_out   (out16),
        .sample_valid (valid16),
        .sample_ready (sample_ready),
        .busy         (busy16),
        .overrun_cnt  (ovr16)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_cnt[v] = 0;
            m_pol[v] = 0;
        end
        m_ovr = 0;
    endtask

    // Square-wave phase model: each service either silences, counts, or toggles the voice.
    task automatic model_sample(output int e4, output int e16);
        int units = 0;
        for (int v = 0; v < 4; v++) begin
            int h = int'(hp[v]);
            if (h == 0) begin
                m_cnt[v] = 0;
                m_pol[v] = 0;
            end else begin
`ifdef VOICE_MASK_EN
                if (!mask[v]) units += (m_pol[v] != 0) ? 1 : -1;
`else
                units += (m_pol[v] != 0) ? 1 : -1;
`endif
                if (m_cnt[v] + 1 >= h) begin
                    m_cnt[v] = 0;
                    m_pol[v] = 1 - m_pol[v];
                end else begin
                    m_cnt[v] = m_cnt[v] + 1;
                end
            end
        end
        e4  = sat16(units * 4096);
        e16 = sat16(units * 16384);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
    endtask

    task automatic do_sample(input string tag);
        int e4, e16, lat;
        model_sample(e4, e16);
        enable = 1'b1;
        pulse_req();
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (valid4 === 1'b1) break;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_valid16"}, {31'd0, valid16}, 1);
        check({tag, "_out4"}, $signed(out4), e4);
        check({tag, "_out16"}, $signed(out16), e16);
        if (sample_ready) begin
            @(negedge clk);
            check({tag, "_busy_after"}, {30'd0, busy4, busy16}, 0);
            check({tag, "_valid_after"}, {31'd0, valid4}, 0);
        end
    endtask

    initial begin
        int e4, e16;
        reset        = 1'b1;
        enable       = 1'b0;
        sample_req   = 1'b0;
        sample_ready = 1'b1;
        mask         = 4'b0000;
        for (int v = 0; v < 4; v++) hp[v] = 16'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_out", $signed(out4), 0);
        check("rst_valid_busy", {29'd0, valid4, busy4, busy16}, 0);
        check("rst_ovr", {24'd0, ovr4}, 0);

        do_sample("silent");

        // Disabled request is ignored entirely.
        enable = 1'b0;
        pulse_req();
        @(negedge clk);
        check("disabled_busy", {31'd0, busy4}, 0);
        check("disabled_ovr", {24'd0, ovr4}, m_ovr);

        hp[0] = 16'd2;
        for (int i = 0; i < 6; i++) do_sample($sformatf("hp2_s%0d", i));

        for (int v = 0; v < 4; v++) hp[v] = 16'd1;
        do_sample("sat_neg");
        do_sample("sat_pos");

        // Stalled consumer: extra requests are dropped and counted.
        hp[0] = 16'd3; hp[1] = 16'd0; hp[2] = 16'd2; hp[3] = 16'd1;
        sample_ready = 1'b0;
        do_sample("stall");
        for (int c = 0; c < 20; c++) begin
            if (c == 2 || c == 9 || c == 15) begin
                sample_req = 1'b1;
                m_ovr++;
            end else begin
                sample_req = 1'b0;
            end
            @(negedge clk);
            if (c == 19) begin
                check("stall_out_stable", $signed(out4), e4);
            end
            if (c == 0) begin
                e4 = int'($signed(out4));
            end
        end
        sample_req = 1'b0;
        check("stall_valid_held", {31'd0, valid4}, 1);
        check("ovr_three", {24'd0, ovr4}, m_ovr);
        check("ovr_three_16", {24'd0, ovr16}, m_ovr);

        sample_req = 1'b1;
        repeat (260) @(negedge clk);
        sample_req = 1'b0;
        m_ovr = 255;
        check("ovr_saturate", {24'd0, ovr4}, m_ovr);

        sample_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", {31'd0, valid4}, 0);
        check("stall_release_busy", {31'd0, busy4}, 0);

        // Reset while voice 2 is being accumulated.
        enable = 1'b1;
        pulse_req();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("midrst_busy", {31'd0, busy4}, 0);
        check("midrst_valid", {31'd0, valid4}, 0);
        check("midrst_ovr", {24'd0, ovr4}, 0);
        check("midrst_out", $signed(out4), 0);
        e16 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid4 === 1'b1 || valid16 === 1'b1) e16 = 1;
        end
        check("midrst_no_emit", e16, 0);
        for (int v = 0; v < 4; v++) hp[v] = 16'd0;
        hp[0] = 16'd2;
        do_sample("post_rst");

        for (int i = 0; i < 12; i++) begin
            for (int v = 0; v < 4; v++) hp[v] = 16'($urandom_range(0, 3));
            do_sample($sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef VOICE_MASK_EN
        for (int v = 0; v < 4; v++) hp[v] = 16'd0;
        hp[0] = 16'd1;
        hp[1] = 16'd1;
        mask  = 4'b0001;
        for (int i = 0; i < 3; i++) do_sample($sformatf("mask%0d", i));
        mask = 4'b0000;
        for (int i = 0; i < 3; i++) do_sample($sformatf("unmask%0d", i));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
